modn_syndown_counter: RTL and testbench

//  Loadable modulo-N synchronous down counter. It is the count-down companion to the team's MOD-12 loadable up counter.

---
 rtl/modn_syndown_counter_pkg.sv | 15 +
 rtl/modn_syndown_counter.sv | 84 ++++++++
 tb/tb_modn_syndown_counter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/modn_syndown_counter_pkg.sv
// Shared definitions for the modulo-N down counter: FSM state encoding and
// the terminal-value helper used to size the reload constant.
package modn_syndown_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cnt_state_e;

    // Highest legal count for a given modulus.
    function automatic int cnt_max(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/modn_syndown_counter.sv
// Loadable modulo-N synchronous down counter with auto-reload / one-shot modes
// and a combinational terminal count for cascading into a following stage.
module modn_syndown_counter
    import modn_syndown_counter_pkg::*;
#(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("modn_syndown_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(MODULUS));

    cnt_state_e       state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             wrap_n, done_n, load_err_n;
    logic             load_over;

    assign load_over = (load_val > CNT_MAX);

    // Borrow into the next stage: no latency, so it must not come from a register.
    assign tc = (state == ST_RUN) && en && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            count    <= CNT_MAX;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            wrap     <= wrap_n;
            done     <= done_n;
            load_err <= load_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        wrap_n     = 1'b0;
        done_n     = done;
        load_err_n = 1'b0;

        if (load) begin
            count_n    = load_over ? CNT_MAX : load_val;
            state_n    = ST_RUN;
            done_n     = 1'b0;
            load_err_n = load_over;
        end else if (count > CNT_MAX) begin
            // Out-of-range count can only come from an upset; recover quietly.
            count_n = CNT_MAX;
        end else if (state == ST_HALT) begin
            count_n = '0;
        end else if (en) begin
            if (count != '0) begin
                count_n = count - 1'b1;
            end else if (oneshot) begin
                state_n = ST_HALT;
                done_n  = 1'b1;
            end else begin
                count_n = CNT_MAX;
                wrap_n  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modn_syndown_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the counter's rules.
module tb_modn_syndown_counter;

    localparam int M = 12;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, load, oneshot;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc, wrap, done, load_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference state
    int m_cnt;
    bit m_halt, m_wrap, m_done, m_lerr;
    bit m_valid = 1'b0;

    modn_syndown_counter #(.MODULUS(M), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .oneshot(oneshot), .count(count), .tc(tc), .wrap(wrap),
        .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit l, input int lv,
                                       input bit e, input bit os);
        if (r) begin
            m_cnt = M - 1; m_halt = 0; m_wrap = 0; m_done = 0; m_lerr = 0;
            return;
        end
        m_wrap = 0;
        m_lerr = 0;
        if (l) begin
            m_lerr = (lv > M - 1);
            m_cnt  = (lv > M - 1) ? M - 1 : lv;
            m_halt = 0;
            m_done = 0;
        end else if (!m_halt && e) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else if (os) begin m_halt = 1; m_done = 1; end
            else begin m_cnt = M - 1; m_wrap = 1; end
        end
    endfunction

    // One clock: apply inputs, check tc combinationally, then check registers after the edge.
    task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit os);
        rst = r; load = l; load_val = W'(lv); en = e; oneshot = os;
        #1;
        if (m_valid) chk("tc", 32'(tc), 32'(!m_halt && e && m_cnt == 0));
        @(posedge clk);
        model_step(r, l, lv, e, os);
        m_valid = 1'b1;
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("done", 32'(done), 32'(m_done));
        chk("load_err", 32'(load_err), 32'(m_lerr));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; oneshot = 1'b0;

        // T1 reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t1_count", 32'(count), 32'd11);

        // T2 load 5 and count down to 0
        cyc(0, 1, 5, 0, 0);
        chk("t2_load", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        chk("t2_zero", 32'(count), 32'd0);
        en = 1'b1; #1;
        chk("t2_tc", 32'(tc), 32'd1);

        // T3 auto-reload
        cyc(0, 0, 0, 1, 0);
        chk("t3_reload", 32'(count), 32'd11);
        chk("t3_wrap", 32'(wrap), 32'd1);
        cyc(0, 0, 0, 1, 0);
        chk("t3_wrap_clr", 32'(wrap), 32'd0);

        // T4 one-shot halt then reload
        cyc(0, 1, 2, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
        chk("t4_done", 32'(done), 32'd1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, (i < 5));
        chk("t4_hold", 32'(count), 32'd0);
        cyc(0, 1, 7, 0, 1);
        chk("t4_reload", 32'(count), 32'd7);
        chk("t4_done_clr", 32'(done), 32'd0);

        // T5 illegal load, then load beats en
        cyc(0, 1, 14, 0, 0);
        chk("t5_clamp", 32'(count), 32'd11);
        chk("t5_err", 32'(load_err), 32'd1);
        cyc(0, 1, 3, 1, 0);
        chk("t5_load_win", 32'(count), 32'd3);
        chk("t5_err_clr", 32'(load_err), 32'd0);
        cyc(0, 1, 15, 1, 0);

        // T6 reset beats simultaneous load
        cyc(0, 1, 4, 0, 0);
        cyc(1, 1, 2, 1, 0);
        chk("t6_rst", 32'(count), 32'd11);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("t6_hold", 32'(count), 32'd11);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int p;
            bit r, l, e, os;
            p  = int'($urandom_range(0, 99));
            r  = (p < 2);
            l  = (p >= 2 && p < 12);
            e  = ($urandom_range(0, 3) != 0);
            os = ($urandom_range(0, 1) == 1);
            cyc(r, l, int'($urandom_range(0, 15)), e, os);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
